// File: rtl/inst_loader.sv
// Byte-stream instruction loader: packs LSB-first bytes into 32-bit words and writes them to instruction memory.
// Optional feature: define LOADER_CSUM_EN to keep a running XOR checksum of written words.
module inst_loader #(
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_go,
    input  logic              load_stop,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       csum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  byte_idx_r;
    logic        start_s;
    logic        accept_s;
    logic        last_word_s;

    // Handshake and session-control decodes
    always_comb begin
        start_s     = ((state_r == IDLE) || (state_r == DONE)) && load_go;
        accept_s    = (state_r == COLLECT) && in_valid && !load_stop;
        last_word_s = ((word_count + (ADDR_W+1)'(1)) == MAX_CNT);
    end

    // Next-state logic; stop beats a same-cycle byte, and a write in flight always finishes
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (load_go) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = state_r;
                end
            end
            COLLECT: begin
                if (load_stop) begin
                    state_next_s = DONE;
                end else if (in_valid && (byte_idx_r == 2'd3)) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            WRITE: begin
                if (load_stop || last_word_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register, registered status outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_idx_r <= 2'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            word_count <= '0;
        end else begin
            state_r  <= state_next_s;
            in_ready <= (state_next_s == COLLECT);
            mem_we   <= (state_next_s == WRITE);
            busy     <= (state_next_s == COLLECT) || (state_next_s == WRITE);
            done     <= (state_next_s == DONE);
            if (start_s) begin
                byte_idx_r <= 2'd0;
                mem_addr   <= '0;
                word_count <= '0;
            end else if (accept_s) begin
                mem_wdata[{byte_idx_r, 3'b000} +: 8] <= in_data;
                byte_idx_r <= byte_idx_r + 2'd1;
            end else if (state_r == WRITE) begin
                word_count <= word_count + (ADDR_W+1)'(1);
                // Hold the address on the final word so it never wraps at full depth
                if (!last_word_s) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end else begin
                    mem_addr <= mem_addr;
                end
            end else begin
                byte_idx_r <= byte_idx_r;
            end
        end
    end

`ifdef LOADER_CSUM_EN
    // Running XOR of every word written this session
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= 32'd0;
        end else if (start_s) begin
            csum <= 32'd0;
        end else if (state_r == WRITE) begin
            csum <= csum ^ mem_wdata;
        end else begin
            csum <= csum;
        end
    end
`else
    assign csum = 32'd0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a session-level reference model.
module tb_inst_loader;

    localparam int ADDR_W    = 2;
    localparam int MAX_WORDS = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_go;
    logic              load_stop;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       csum;

    inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .load_go(load_go), .load_stop(load_stop),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .word_count(word_count), .csum(csum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_we_seen = 0;

    // Reference model: session active flag, pending write, collected word and totals
    bit          m_active, m_wr, m_done, m_acc;
    int          m_k, m_words, m_writes;
    logic [31:0] m_word, m_csum;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) n_we_seen++;
    end

    task automatic step(input logic rn, input logic go, input logic stop,
                        input logic v, input logic [7:0] d);
        logic [31:0] exp_csum;
        rst_n = rn; load_go = go; load_stop = stop; in_valid = v; in_data = d;
        @(posedge clk);
        m_acc = 1'b0;
        if (!rn) begin
            m_active = 0; m_wr = 0; m_done = 0; m_k = 0; m_words = 0;
            m_word = 32'd0; m_csum = 32'd0;
        end else if (!m_active) begin
            if (go) begin
                m_active = 1; m_done = 0; m_k = 0; m_words = 0; m_csum = 32'd0;
            end
        end else if (m_wr) begin
            m_wr = 0;
            m_csum = m_csum ^ m_word;
            m_words++;
            if (stop || m_words == MAX_WORDS) begin
                m_active = 0; m_done = 1;
            end
        end else if (stop) begin
            m_active = 0; m_done = 1;
        end else if (v) begin
            m_acc = 1'b1;
            m_word[8*m_k +: 8] = d;
            m_k++;
            if (m_k == 4) begin
                m_k = 0; m_wr = 1; m_writes++;
            end
        end
        #1;
`ifdef LOADER_CSUM_EN
        exp_csum = m_csum;
`else
        exp_csum = 32'd0;
`endif
        chk_eq("in_ready", 32'(in_ready), 32'(m_active && !m_wr));
        chk_eq("busy", 32'(busy), 32'(m_active));
        chk_eq("done", 32'(done), 32'(m_done));
        chk_eq("mem_we", 32'(mem_we), 32'(m_wr));
        chk_eq("word_count", 32'(word_count), 32'(m_words));
        chk_eq("csum", csum, exp_csum);
        if (m_wr) begin
            chk_eq("mem_addr", 32'(mem_addr), 32'(m_words));
            chk_eq("mem_wdata", mem_wdata, m_word);
        end
        if (!rn) begin
            chk_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk_eq("rst_mem_wdata", mem_wdata, 32'd0);
        end
    endtask

    // Stream a word with in_valid held high, retrying bytes that are not accepted
    task automatic send_word(input logic [31:0] w);
        int i = 0;
        for (int n = 0; n < 12 && i < 4; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, w[8*i +: 8]);
            if (m_acc) i++;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        m_active = 0; m_wr = 0; m_done = 0; m_acc = 0; m_k = 0; m_words = 0;
        m_writes = 0; m_word = 32'd0; m_csum = 32'd0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_eq("reset_busy", 32'(busy), 32'd0);

        // Single word 0x00100513
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        send_word(32'h00100513);
        chk_eq("w0_we", 32'(mem_we), 32'd1);
        chk_eq("w0_data", mem_wdata, 32'h00100513);
        idle(1);
        chk_eq("w0_count", 32'(word_count), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Three words back-to-back, then stop
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
        chk_eq("b2b_count", 32'(word_count), 32'd3);

        // Two bytes then stop: nothing written
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hAB);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hCD);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hEF);
        chk_eq("stop_done", 32'(done), 32'd1);
        chk_eq("stop_count", 32'(word_count), 32'd0);

        // Run to automatic completion and keep offering bytes
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int w = 0; w < MAX_WORDS + 1; w++) send_word($urandom);
        chk_eq("full_done", 32'(done), 32'd1);
        chk_eq("full_ready", 32'(in_ready), 32'd0);

        // Checksum pair
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        send_word(32'hA5A5A5A5);
        send_word(32'h0F0F0F0F);
        idle(1);
`ifdef LOADER_CSUM_EN
        chk_eq("csum_pair", csum, 32'hAAAAAAAA);
`else
        chk_eq("csum_pair", csum, 32'h00000000);
`endif
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Reset after two bytes of a word
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
        chk_eq("rst_mid_busy", 32'(busy), 32'd0);
        idle(3);

        // Random traffic, including go while busy and occasional resets
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom));
        end
        idle(2);
        chk_eq("we_pulses", 32'(n_we_seen), 32'(m_writes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
